// File: rtl/aes_mode_ctrl.sv
// Block-cipher mode controller (ECB / CBC / CTR) in front of a fixed-latency, in-order cipher core.
// Results land in a credit-protected FIFO, so the core never has to stall.
module aes_mode_ctrl #(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 32,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy,
  output logic               err,
  output logic               core_enable,
  output logic [BLOCK_W-1:0] core_plaintext,
  input  logic [BLOCK_W-1:0] core_ciphertext,
  input  logic               core_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);
  localparam logic [BLOCK_W-1:0] CTR_MASK = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_W);

  typedef enum logic [1:0] {
    MODE_ECB = 2'b00,
    MODE_CBC = 2'b01,
    MODE_CTR = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  mode_e              mode_q, mode_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  logic [BLOCK_W-1:0] res_mem [DEPTH];
  logic [PTR_W-1:0]   res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;

  logic [BLOCK_W-1:0] pend_mem [DEPTH];
  logic [PTR_W-1:0]   pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;

  logic [CNT_W:0]     credit;
  logic               start_ok, accept, ret;
  logic               res_push, res_pop, pend_push, pend_pop;
  logic [BLOCK_W-1:0] res_push_data, chain_inc;

  assign busy      = (inflight_q != '0) || (res_cnt_q != '0);
  assign start_ok  = start && !busy;
  assign credit    = {1'b0, inflight_q} + {1'b0, res_cnt_q};

  // CBC needs the previous ciphertext before the next block can be chained.
  assign in_ready  = rst_n && (credit < CREDIT_MAX) && !start &&
                     ((mode_q != MODE_CBC) || (inflight_q == '0));
  assign accept    = in_valid && in_ready;
  assign ret       = core_valid && (inflight_q != '0);

  assign core_enable = accept;
  assign out_valid   = (res_cnt_q != '0);
  assign out_data    = res_mem[res_rd_q];
  assign err         = err_q;

  assign res_push  = ret;
  assign res_pop   = out_valid && out_ready;
  assign pend_push = accept && (mode_q == MODE_CTR);
  assign pend_pop  = ret && (mode_q == MODE_CTR);

  // Only the low CTR_W bits of the counter block count; the carry out of them is discarded.
  assign chain_inc = ((chain_q + BLOCK_W'(1)) & CTR_MASK) | (chain_q & ~CTR_MASK);

  always_comb begin
    core_plaintext = in_data;
    case (mode_q)
      MODE_CBC: core_plaintext = in_data ^ chain_q;
      MODE_CTR: core_plaintext = chain_q;
      default:  core_plaintext = in_data;
    endcase
  end

  always_comb begin
    res_push_data = core_ciphertext;
    if (mode_q == MODE_CTR) begin
      res_push_data = core_ciphertext ^ pend_mem[pend_rd_q];
    end
  end

  always_comb begin
    mode_d     = mode_q;
    chain_d    = chain_q;
    err_d      = err_q;
    inflight_d = inflight_q;

    if (start_ok) begin
      if (mode == 2'b11) begin
        err_d = 1'b1;
      end else begin
        mode_d  = mode_e'(mode);
        chain_d = iv;
        err_d   = 1'b0;
      end
    end
    if (accept && (mode_q == MODE_CTR)) begin
      chain_d = chain_inc;
    end
    if (ret && (mode_q == MODE_CBC)) begin
      chain_d = core_ciphertext;
    end

    case ({accept, ret})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    res_wr_d  = res_wr_q + PTR_W'(res_push);
    res_rd_d  = res_rd_q + PTR_W'(res_pop);
    res_cnt_d = res_cnt_q + CNT_W'(res_push) - CNT_W'(res_pop);
    pend_wr_d = pend_wr_q + PTR_W'(pend_push);
    pend_rd_d = pend_rd_q + PTR_W'(pend_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= MODE_ECB;
      chain_q    <= '0;
      err_q      <= 1'b0;
      inflight_q <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      res_cnt_q  <= '0;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
    end else begin
      mode_q     <= mode_d;
      chain_q    <= chain_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      res_wr_q   <= res_wr_d;
      res_rd_q   <= res_rd_d;
      res_cnt_q  <= res_cnt_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
    end
  end

  // Storage arrays carry no reset; the pointers alone define their contents.
  always_ff @(posedge clk) begin
    if (res_push) begin
      res_mem[res_wr_q] <= res_push_data;
    end
    if (pend_push) begin
      pend_mem[pend_wr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl around a 3-cycle stand-in cipher core
// (byte-rotate then XOR with the key), exercising ECB, CBC, CTR, backpressure, reset and err.
module tb_aes_mode_ctrl;

  localparam int BW  = 128;
  localparam int LAT = 3;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, out_ready;
  logic [1:0]    mode;
  logic [BW-1:0] iv, in_data;
  logic          in_ready, out_valid, busy, err, core_enable, core_valid;
  logic [BW-1:0] out_data, core_plaintext, core_ciphertext;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [BW-1:0] out_log [$];
  logic [BW-1:0] pt_log  [$];

  aes_mode_ctrl #(.BLOCK_W(BW), .CTR_W(32), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err), .core_enable(core_enable), .core_plaintext(core_plaintext),
    .core_ciphertext(core_ciphertext), .core_valid(core_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] cipher(input logic [127:0] x);
    return {x[119:0], x[127:120]} ^ KEY;
  endfunction

  // Stand-in core: fixed latency, in order, never stalls, not reset.
  logic [LAT-1:0] pv = '0;
  logic [BW-1:0]  pd [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], core_enable};
    pd[0] <= cipher(core_plaintext);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
  end
  assign core_valid      = pv[LAT-1];
  assign core_ciphertext = pd[LAT-1];

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) out_log.push_back(out_data);
    if (core_enable) pt_log.push_back(core_plaintext);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [127:0] v);
    start = 1'b1; mode = m; iv = v;
    #1;
    check("start_blocks_in_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, output int acc_cyc);
    int k;
    in_valid = 1'b1; in_data = d;
    #1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk); #1; k++;
    end
    check("send_in_ready_timeout", (k < 100), 1);
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (out_log.size() < n && k < 200) begin
      @(negedge clk); k++;
    end
    check("wait_out_timeout", (out_log.size() >= n), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p [4];
    logic [127:0] ivc, ivt, ivw, wrap_ctr, ctr, c1, c2, base;
    int a [4];
    int acc;
    logic seen;

    p[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    p[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    p[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    p[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    ivc  = 128'h000102030405060708090a0b0c0d0e0f;
    ivt  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    ivw  = 128'h00112233445566778899aabbffffffff;
    wrap_ctr = 128'h00112233445566778899aabb00000000;
    base = 128'hdeadbeef000000000000000000000000;

    rst_n = 1'b0; start = 1'b0; mode = 2'b00; iv = '0;
    in_valid = 1'b1; in_data = p[0]; out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_core_enable", core_enable, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // ECB single block: latency and output hold
    do_start(2'b00, '0);
    send(p[0], a[0]);
    check("ecb_lat_n0", out_valid, 0);
    @(negedge clk); check("ecb_lat_n1", out_valid, 0);
    @(negedge clk); check("ecb_lat_n2", out_valid, 0);
    @(negedge clk); check("ecb_lat_n3", out_valid, 1);
    check("ecb_data", out_data, cipher(p[0]));
    @(negedge clk);
    check("ecb_hold_valid", out_valid, 1);
    check("ecb_hold_data", out_data, cipher(p[0]));
    out_ready = 1'b1;
    @(negedge clk);
    check("ecb_popped", out_valid, 0);
    check("ecb_busy_low", busy, 0);

    // ECB back-to-back stream
    out_log.delete();
    for (int i = 0; i < 4; i++) send(p[i], a[i]);
    check("ecb_rate", a[3] - a[0], 3);
    wait_out(4);
    for (int i = 0; i < 4; i++) check($sformatf("ecb_stream%0d", i), out_log[i], cipher(p[i]));

    // CBC: chaining and one block in flight
    do_start(2'b01, ivc);
    out_log.delete();
    send(p[0], a[0]);
    check("cbc_in_ready_low", in_ready, 0);
    send(p[1], a[1]);
    check("cbc_gap", a[1] - a[0], LAT + 1);
    wait_out(2);
    c1 = cipher(p[0] ^ ivc);
    c2 = cipher(p[1] ^ c1);
    check("cbc_blk0", out_log[0], c1);
    check("cbc_blk1", out_log[1], c2);

    // CTR: four blocks streamed
    do_start(2'b10, ivt);
    out_log.delete(); pt_log.delete();
    for (int i = 0; i < 4; i++) send(p[i], a[i]);
    check("ctr_rate", a[3] - a[0], 3);
    wait_out(4);
    check("ctr_core_in0", pt_log[0], ivt);
    for (int i = 0; i < 4; i++) begin
      ctr = {ivt[127:32], ivt[31:0] + 32'(i)};
      check($sformatf("ctr_blk%0d", i), out_log[i], cipher(ctr) ^ p[i]);
    end

    // CTR low-word wrap
    do_start(2'b10, ivw);
    out_log.delete(); pt_log.delete();
    send(p[0], a[0]);
    send(p[1], a[1]);
    wait_out(2);
    check("wrap_core_in0", pt_log[0], ivw);
    check("wrap_core_in1", pt_log[1], wrap_ctr);
    check("wrap_blk1", out_log[1], cipher(wrap_ctr) ^ p[1]);

    // Backpressure: exactly DEPTH accepts, then in-order drain
    do_start(2'b00, '0);
    out_ready = 1'b0;
    out_log.delete();
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_data = base + 128'(acc);
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_accepts", acc, 8);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_out(8);
    for (int i = 0; i < 8; i++) check($sformatf("bp_drain%0d", i), out_log[i], cipher(base + 128'(i)));
    check("bp_busy_low", busy, 0);

    // Reset with three blocks in flight; late core returns are dropped
    out_log.delete();
    for (int i = 0; i < 3; i++) send(p[i], a[i]);
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = p[3];
    #1;
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    check("midrst_core_enable", core_enable, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_stray_dropped", seen, 0);
    check("midrst_busy", busy, 0);
    check("midrst_no_output", out_log.size(), 0);

    // err: reserved mode sets it and leaves mode/chain alone; a valid start clears it
    do_start(2'b01, ivc);
    do_start(2'b11, '0);
    check("err_set", err, 1);
    out_log.delete();
    send(p[0], a[0]);
    wait_out(1);
    check("err_mode_kept", out_log[0], cipher(p[0] ^ ivc));
    do_start(2'b00, '0);
    check("err_cleared", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_mode_ctrl.md
# aes_mode_ctrl

Parametrised block-cipher mode controller that sits between the stream-facing datapath and the `enc` AES-128 encryption core. It accepts plaintext blocks over a ready/valid handshake and applies ECB, CBC or CTR chaining. It drives the core's `enable`/`plaintext` inputs and post-processes `ciphertext`/`valid_out`, buffering results in an output FIFO with backpressure. The key is wired directly to the core and is outside this block's scope.

## Interface
- `BLOCK_W`, 128: block width in bits; must equal the core width.
- `CTR_W`, 32: number of low-order bits of the counter block incremented in CTR mode; range 1..`BLOCK_W`.
- `DEPTH`, 16: result FIFO depth and maximum number of blocks in flight; power of 2, ≥ 2.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; latches `mode` and `iv`.
- `mode` in 2: 00 ECB, 01 CBC, 10 CTR, 11 reserved.
- `iv` in `BLOCK_W`: IV (CBC) or initial counter block (CTR).
- `in_valid` in 1, `in_ready` out 1, `in_data` in `BLOCK_W`: input block handshake.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `BLOCK_W`: output block handshake.
- `busy` out 1: high while any block is in flight or the FIFO is non-empty.
- `err` out 1: sticky; set by `start` with `mode`=11.
- `core_enable` out 1, `core_plaintext` out `BLOCK_W`: core inputs.
- `core_ciphertext` in `BLOCK_W`, `core_valid` in 1: core outputs. The core returns results in order, has fixed latency and cannot stall.

## Operation
- **Registers:**
  - `mode_r`.
  - `chain` (`BLOCK_W`).
  - `inflight` counter (0..`DEPTH`).
  - Result FIFO (`DEPTH` × `BLOCK_W`).
  - Pending-plaintext FIFO (`DEPTH` × `BLOCK_W`), used only in CTR mode.
- **start:** honoured only when `busy`=0.
  - `mode` 00/01/10: `mode_r`←`mode`, `chain`←`iv`, `err`←0.
  - `mode` 11: `err`←1; `mode_r` and `chain` unchanged.
  - When `busy`=1, `start` is ignored entirely.
- **Credit:** `credit` = `inflight` + result FIFO count.
  - `in_ready` = `rst_n` & (`credit` < `DEPTH`) & ~`start`.
  - In CBC, `in_ready` additionally requires `inflight`=0.
- **Accept** (`in_valid` & `in_ready`): `core_enable`=1 in the same cycle (combinational); `inflight`+1.
  - ECB: `core_plaintext` = `in_data`.
  - CBC: `core_plaintext` = `in_data` ^ `chain`.
  - CTR: `core_plaintext` = `chain`; push `in_data` into the pending FIFO; `chain[CTR_W-1:0]` += 1 mod 2^`CTR_W`; upper bits unchanged.
- **Return** (`core_valid` & `inflight`>0): `inflight`−1; push to the result FIFO.
  - ECB: pushed value = `core_ciphertext`.
  - CBC: pushed value = `core_ciphertext`; `chain`←`core_ciphertext`.
  - CTR: pushed value = `core_ciphertext` ^ pending-FIFO head; pop the pending FIFO.
- **Stray returns:** `core_valid` with `inflight`=0 (e.g. after reset mid-operation) is dropped with no state change.
- **Simultaneous accept and return:** `inflight` is unchanged.
- **Output:** `out_valid` = result FIFO non-empty; `out_data` = head; pop on `out_valid` & `out_ready`.
  - Simultaneous push and pop is legal at any occupancy.
  - Overflow cannot occur because of the credit rule.
- **Mode changes** take effect only via `start`; blocks in flight complete under `mode_r`.

## Timing
- **Reset** (`rst_n`=0 at an edge):
  - `inflight`=0; both FIFOs empty.
  - `mode_r`=00, `chain`=0, `err`=0.
  - `out_valid`=0, `busy`=0, `core_enable`=0.
  - `in_ready`=0 while `rst_n` is low.
- **Reset mid-operation:** discards all in-flight and buffered blocks.
- **Latency:** `out_valid` rises 1 cycle after the `core_valid` edge, i.e. core latency + 1 after accept.
- **Throughput:**
  - ECB/CTR: 1 block/cycle, limited only by credit.
  - CBC: 1 block per (core latency + 1) cycles.
- **Stability:** `out_data` is held while `out_valid` & ~`out_ready`.
- **Start timing:** a `start` accepted at edge N applies to an input accepted at edge N+1 or later; `in_ready`=0 in the `start` cycle.
- **busy** is registered-state derived; it falls in the cycle after the last FIFO pop.

## Test plan
All cases use key 2b7e151628aed2a6abf7158809cf4f3c and the real `enc` core.
- **ECB:** start `mode`=00; in 6bc1bee22e409f96e93d7e117393172a → out 3ad77bb40d7a3660a89ecaf32466ef97; the 4-block SP800-38A ECB vector streams back-to-back at 1 block/cycle.
- **CBC:** `iv` 000102030405060708090a0b0c0d0e0f; same block → 7649abac8119b246cee98e9b12e9197d; second block ae2d8a57... → 5086cb9b507219ee95db113a917678b2; `in_ready` stays low while 1 block is in flight.
- **CTR:** `iv` f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff; 4 SP800-38A blocks → 874d6191b620e3261bef6864990db6ce, 9806f66b7970fdff8617187bb9fffdff, ...
- **CTR wrap:** `CTR_W`=32, `iv` low word ffffffff; the second core input has low word 00000000 and upper 96 bits unchanged.
- **Backpressure:** `out_ready`=0, stream ECB blocks; `in_ready` falls after exactly `DEPTH` accepts; releasing `out_ready` drains all `DEPTH` blocks in order with no loss.
- **Reset/err:**
  - Assert `rst_n`=0 with 3 blocks in flight; the late `core_valid` pulses are dropped and `out_valid` stays 0.
  - Start `mode`=11 → `err`=1; a subsequent start with `mode`=00 → `err`=0.
